// File: rtl/updi_double_break.sv
// Purpose: drives the UPDI double-break (break, gap, break, recover) that resets the target's UPDI interface.
// Latency: busy from the accepting edge; done 1+2*BREAK+GAP+RECOVER cycles after start, plus any wait for tx_idle.
// Backpressure: holds in WAIT_TX until the UART TX path is idle; start is ignored while busy (no queuing).
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   start     request a double break (accepted only when idle)
//   tx_idle   UART TX shifter and TX FIFO both empty
//   busy      sequence in progress
//   done      sequence completed, sticky until the next accepted start or reset
//   line_low  pin mux override, 1 forces the UPDI pin low
//   rx_flush  level request to the UART RX FIFO to discard data while busy
module updi_double_break #(
    parameter int BREAK_CLKS   = 300000,
    parameter int GAP_CLKS     = 12000,
    parameter int RECOVER_CLKS = 12000,
    parameter int CNT_BITS     = $clog2((((BREAK_CLKS > GAP_CLKS) ? BREAK_CLKS : GAP_CLKS) > RECOVER_CLKS
                                         ? ((BREAK_CLKS > GAP_CLKS) ? BREAK_CLKS : GAP_CLKS)
                                         : RECOVER_CLKS) + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tx_idle,
    output logic busy,
    output logic done,
    output logic line_low,
    output logic rx_flush
);

    if (BREAK_CLKS < 1 || GAP_CLKS < 1 || RECOVER_CLKS < 1) begin : g_bad_len
        $error("updi_double_break: BREAK_CLKS, GAP_CLKS and RECOVER_CLKS must all be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TX,
        S_BREAK1,
        S_GAP,
        S_BREAK2,
        S_RECOVER
    } state_t;

    // Counters load length-1 so each phase lasts exactly its length in cycles.
    localparam logic [CNT_BITS-1:0] BREAK_LOAD   = CNT_BITS'(BREAK_CLKS - 1);
    localparam logic [CNT_BITS-1:0] GAP_LOAD     = CNT_BITS'(GAP_CLKS - 1);
    localparam logic [CNT_BITS-1:0] RECOVER_LOAD = CNT_BITS'(RECOVER_CLKS - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE      = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ZERO     = '0;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                line_low_q, line_low_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_TX;
                    done_d  = 1'b0;
                end
            end
            S_WAIT_TX: begin
                if (tx_idle) begin
                    state_d = S_BREAK1;
                    cnt_d   = BREAK_LOAD;
                end
            end
            S_BREAK1: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_BREAK2;
                    cnt_d   = BREAK_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_BREAK2: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_RECOVER;
                    cnt_d   = RECOVER_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RECOVER: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Outputs decode the next state so the registered copies line up with state_q.
        busy_d     = (state_d != S_IDLE);
        line_low_d = (state_d == S_BREAK1) || (state_d == S_BREAK2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            line_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            line_low_q <= line_low_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign line_low = line_low_q;
    // The RX FIFO is flushed for the whole sequence, so it shares the busy flop.
    assign rx_flush = busy_q;

endmodule
